// File: rtl/gcm_seq_ctrl_if.sv
// rtl/gcm_seq_ctrl_if.sv - Control/handshake bundle between the GCM sequencer and its environment
interface gcm_seq_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              mode_dec;
  logic [ADDR_W-1:0] blk_cnt;
  logic [ADDR_W-1:0] aad_cnt;
  logic              aes_done;
  logic              gf_done;
  logic              aes_start;
  logic [1:0]        aes_sel;
  logic              gf_start;
  logic [1:0]        gf_sel;
  logic              h_load;
  logic              j0_cap;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              xor_en;
  logic              tag_en;
  logic              busy;
  logic              done;

  modport master (
    input  start, mode_dec, blk_cnt, aad_cnt, aes_done, gf_done,
    output aes_start, aes_sel, gf_start, gf_sel, h_load, j0_cap,
           mem_en, mem_we, mem_addr, xor_en, tag_en, busy, done
  );

  modport slave (
    output start, mode_dec, blk_cnt, aad_cnt, aes_done, gf_done,
    input  aes_start, aes_sel, gf_start, gf_sel, h_load, j0_cap,
           mem_en, mem_we, mem_addr, xor_en, tag_en, busy, done
  );
endinterface

// File: rtl/gcm_seq_ctrl.sv
// rtl/gcm_seq_ctrl.sv - AES-GCM block sequencer (H, EK(J0), CTR, XOR write-back, GHASH, length, tag)
// Optional AAD GHASH phase after J0 is enabled by defining GCM_AAD_EN.
module gcm_seq_ctrl #(
  parameter int ADDR_W     = 6,
  parameter int TAG_ADDR   = 40,
  parameter int H_LOAD_CYC = 16,
  parameter int AAD_BASE   = 32
) (
  input  logic                clk,
  input  logic                rst,
  gcm_seq_ctrl_if.master      bus
);

  localparam int CW = $clog2(H_LOAD_CYC + 1);
  localparam logic [ADDR_W-1:0] TAG_A = TAG_ADDR[ADDR_W-1:0];
  localparam logic [CW-1:0]     H_LAST = CW'(H_LOAD_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_HKEY, S_HLOAD, S_J0,
`ifdef GCM_AAD_EN
    S_AREAD, S_AGF,
`endif
    S_CTR, S_READ, S_XOR, S_WRITE, S_GHASH, S_LEN, S_TAG, S_TAGWR, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              first_q;
  logic [CW-1:0]     hcnt_q, hcnt_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] blk_q, blk_d;
  logic              dec_q, dec_d;
`ifdef GCM_AAD_EN
  localparam logic [ADDR_W-1:0] AAD_A = AAD_BASE[ADDR_W-1:0];
  logic [ADDR_W-1:0] aad_q, aad_d;
`else
  logic              unused_aad;
  assign unused_aad = ^{bus.aad_cnt, AAD_BASE[ADDR_W-1:0]};
`endif

  // Data phase entry: an empty payload goes straight to the length block.
  state_e data_entry;
  assign data_entry = (blk_q == '0) ? S_LEN : S_CTR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      first_q <= 1'b0;
      hcnt_q  <= '0;
      i_q     <= '0;
      blk_q   <= '0;
      dec_q   <= 1'b0;
`ifdef GCM_AAD_EN
      aad_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      first_q <= (state_d != state_q);
      hcnt_q  <= hcnt_d;
      i_q     <= i_d;
      blk_q   <= blk_d;
      dec_q   <= dec_d;
`ifdef GCM_AAD_EN
      aad_q   <= aad_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    hcnt_d        = hcnt_q;
    i_d           = i_q;
    blk_d         = blk_q;
    dec_d         = dec_q;
`ifdef GCM_AAD_EN
    aad_d         = aad_q;
`endif
    bus.aes_start = 1'b0;
    bus.aes_sel   = 2'd0;
    bus.gf_start  = 1'b0;
    bus.gf_sel    = 2'd0;
    bus.h_load    = 1'b0;
    bus.j0_cap    = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.xor_en    = 1'b0;
    bus.tag_en    = 1'b0;
    bus.busy      = (state_q != S_IDLE);
    bus.done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          blk_d   = bus.blk_cnt;
          dec_d   = bus.mode_dec;
`ifdef GCM_AAD_EN
          aad_d   = bus.aad_cnt;
`endif
          i_d     = '0;
          hcnt_d  = '0;
          state_d = S_HKEY;
        end
      end
      S_HKEY: begin
        bus.aes_sel   = 2'd0;
        bus.aes_start = first_q;
        if (bus.aes_done) begin
          hcnt_d  = '0;
          state_d = S_HLOAD;
        end
      end
      S_HLOAD: begin
        bus.h_load = 1'b1;
        if (hcnt_q == H_LAST) state_d = S_J0;
        else                  hcnt_d  = hcnt_q + 1'b1;
      end
      S_J0: begin
        bus.aes_sel   = 2'd1;
        bus.aes_start = first_q;
        if (bus.aes_done) begin
          bus.j0_cap = 1'b1;
          i_d        = '0;
`ifdef GCM_AAD_EN
          state_d    = (aad_q != '0) ? S_AREAD : data_entry;
`else
          state_d    = data_entry;
`endif
        end
      end
`ifdef GCM_AAD_EN
      S_AREAD: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = AAD_A + i_q;
        state_d      = S_AGF;
      end
      S_AGF: begin
        bus.gf_sel   = 2'd3;
        bus.gf_start = first_q;
        if (bus.gf_done) begin
          if (i_q == aad_q - 1'b1) begin
            i_d     = '0;
            state_d = data_entry;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = S_AREAD;
          end
        end
      end
`endif
      S_CTR: begin
        bus.aes_sel   = 2'd2;
        bus.aes_start = first_q;
        if (bus.aes_done) state_d = S_READ;
      end
      S_READ: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = i_q;
        state_d      = S_XOR;
      end
      S_XOR: begin
        bus.xor_en = 1'b1;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = i_q;
        state_d      = S_GHASH;
      end
      S_GHASH: begin
        // Decrypt hashes the ciphertext read from RAM, encrypt hashes the XOR output.
        bus.gf_sel   = dec_q ? 2'd1 : 2'd0;
        bus.gf_start = first_q;
        if (bus.gf_done) begin
          if (i_q == blk_q - 1'b1) begin
            state_d = S_LEN;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = S_CTR;
          end
        end
      end
      S_LEN: begin
        bus.gf_sel   = 2'd2;
        bus.gf_start = first_q;
        if (bus.gf_done) state_d = S_TAG;
      end
      S_TAG: begin
        bus.xor_en = 1'b1;
        bus.tag_en = 1'b1;
        state_d    = S_TAGWR;
      end
      S_TAGWR: begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = TAG_A;
        state_d      = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gcm_seq_ctrl.sv
// tb/tb_gcm_seq_ctrl.sv - Self-checking bench for gcm_seq_ctrl with AES/GF latency responders
module tb_gcm_seq_ctrl;
  localparam int ADDR_W   = 6;
  localparam int TAG_ADDR = 40;
  localparam int HCYC     = 16;
  localparam int AADB     = 32;
`ifdef GCM_AAD_EN
  localparam bit AAD_ON = 1'b1;
`else
  localparam bit AAD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcm_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  gcm_seq_ctrl #(
    .ADDR_W(ADDR_W), .TAG_ADDR(TAG_ADDR), .H_LOAD_CYC(HCYC), .AAD_BASE(AADB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int blk;
    bit dec;
    int aad;
    int aes_lat;
    int gf_lat;
    bit inj;
    int exp_hl;
    int exp_done;
  } vec_t;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_wr_q[$];
  int exp_rd_q[$];
  int exp_gf_q[$];
  int aes_lat = 1, gf_lat = 1;
  bit spur_en = 0;
  bit sb_off = 0;
  int hl_cnt, j0_cnt, done_cnt, gf_seen, wr_total, data_idx, last_rd;
  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // AES / GF latency models; latency 0 answers in the same cycle as the start pulse.
  initial begin : responders
    int aes_c, gf_c;
    bit spur_p;
    aes_c = 0; gf_c = 0; spur_p = 0;
    bus.aes_done = 1'b0;
    bus.gf_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aes_c = 0; gf_c = 0; spur_p = 0;
        bus.aes_done = 1'b0;
        bus.gf_done  = 1'b0;
      end else begin
        bus.aes_done = spur_p;
        spur_p = 0;
        bus.gf_done = 1'b0;
        if (bus.aes_start) aes_c = aes_lat + 1;
        if (aes_c > 0) begin
          aes_c--;
          if (aes_c == 0) bus.aes_done = 1'b1;
        end
        if (bus.gf_start) begin
          gf_c = gf_lat + 1;
          if (spur_en) spur_p = 1;
        end
        if (gf_c > 0) begin
          gf_c--;
          if (gf_c == 0) bus.gf_done = 1'b1;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (bus.mem_en && bus.mem_we) begin
          wr_total++;
          if (!sb_off) begin
            if (exp_wr_q.size() == 0) chk("wr_extra", int'(bus.mem_addr), -1);
            else chk("wr_addr", int'(bus.mem_addr), exp_wr_q.pop_front());
          end
        end else if (bus.mem_en) begin
          last_rd = int'(bus.mem_addr);
          if (!sb_off) begin
            if (exp_rd_q.size() == 0) chk("rd_extra", int'(bus.mem_addr), -1);
            else chk("rd_addr", int'(bus.mem_addr), exp_rd_q.pop_front());
          end
        end
        if (bus.gf_start) begin
          gf_seen++;
          if (!sb_off) begin
            if (exp_gf_q.size() == 0) chk("gf_extra", int'(bus.gf_sel), -1);
            else chk("gf_sel", int'(bus.gf_sel), exp_gf_q.pop_front());
            if (bus.gf_sel < 2'd2) begin
              chk("rd_before_ghash", last_rd, data_idx);
              data_idx++;
            end
          end
        end
        if (bus.h_load) hl_cnt++;
        if (bus.j0_cap) j0_cnt++;
        if (bus.done)   done_cnt++;
      end
    end
  end

  task automatic clear_counts();
    hl_cnt = 0; j0_cnt = 0; done_cnt = 0; gf_seen = 0;
    wr_total = 0; data_idx = 0; last_rd = -1;
  endtask

  task automatic pulse_start(input int blk, input bit dec, input int aad);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.blk_cnt  = ADDR_W'(blk);
    bus.mode_dec = dec;
    bus.aad_cnt  = ADDR_W'(aad);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.blk_cnt  = ADDR_W'(blk + 5);
    bus.mode_dec = ~dec;
    bus.aad_cnt  = ADDR_W'(aad + 3);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    exp_wr_q.delete(); exp_rd_q.delete(); exp_gf_q.delete();
    if (AAD_ON) begin
      for (int k = 0; k < v.aad; k++) begin
        exp_rd_q.push_back(AADB + k);
        exp_gf_q.push_back(3);
      end
    end
    for (int k = 0; k < v.blk; k++) begin
      exp_rd_q.push_back(k);
      exp_wr_q.push_back(k);
      exp_gf_q.push_back(v.dec ? 1 : 0);
    end
    exp_gf_q.push_back(2);
    exp_wr_q.push_back(TAG_ADDR);
    aes_lat = v.aes_lat;
    gf_lat  = v.gf_lat;
    spur_en = v.inj;
    clear_counts();
    pulse_start(v.blk, v.dec, v.aad);
    cyc = 0;
    while (done_cnt == 0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      bus.start   = (v.inj && cyc == 20);
      bus.blk_cnt = ADDR_W'(7);
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    spur_en = 0;
    chk($sformatf("v%0d_done", idx), done_cnt, v.exp_done);
    chk($sformatf("v%0d_hload_cycles", idx), hl_cnt, v.exp_hl);
    chk($sformatf("v%0d_j0_cap", idx), j0_cnt, 1);
    chk($sformatf("v%0d_wr_left", idx), exp_wr_q.size(), 0);
    chk($sformatf("v%0d_rd_left", idx), exp_rd_q.size(), 0);
    chk($sformatf("v%0d_gf_left", idx), exp_gf_q.size(), 0);
    chk($sformatf("v%0d_busy_end", idx), int'(bus.busy), 0);
  endtask

  initial begin : main
    int cyc;
    bus.start = 1'b0; bus.mode_dec = 1'b0; bus.blk_cnt = '0; bus.aad_cnt = '0;
    clear_counts();
    //            blk dec aad aesL gfL inj hl  done
    vecs[0] = '{2,  0,  0, 10,  8, 0, HCYC, 1};
    vecs[1] = '{2,  1,  0, 10,  8, 0, HCYC, 1};
    vecs[2] = '{0,  0,  0,  3,  2, 0, HCYC, 1};
    vecs[3] = '{3,  1,  0,  0,  0, 0, HCYC, 1};
    vecs[4] = '{2,  0,  0,  5,  6, 1, HCYC, 1};
    vecs[5] = '{63, 1,  0,  1,  1, 0, HCYC, 1};
    vecs[6] = '{1,  0,  2,  4,  3, 0, HCYC, 1};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_mem_en", int'(bus.mem_en), 0);
    chk("rst_aes_start", int'(bus.aes_start), 0);
    chk("rst_h_load", int'(bus.h_load), 0);
    chk("rst_done", int'(bus.done), 0);
    rst = 1'b0;

    for (int n = 0; n < 7; n++) run_vec(n, vecs[n]);

    // Reset while block 1 is in GHASH: controller must drop to IDLE, no more writes.
    sb_off = 1;
    aes_lat = 4; gf_lat = 8;
    clear_counts();
    pulse_start(3, 0, 0);
    cyc = 0;
    while (gf_seen < 2 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid_reached_gh1", gf_seen, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_mem_we", int'(bus.mem_we), 0);
    rst = 1'b0;
    wr_total = 0;
    repeat (40) @(negedge clk);
    #2;
    chk("rst_mid_no_writes", wr_total, 0);
    chk("rst_mid_idle", int'(bus.busy), 0);
    chk("rst_mid_no_done", done_cnt, 0);
    sb_off = 0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
